// File: rtl/answer_pkg.sv
// Shared types and constants for the answering-machine round sequencer.
package answer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        ANSWERING = 3'd2,
        DONE      = 3'd3
    } state_t;

    localparam int unsigned SCORE_MAX = 9;
    localparam int unsigned REMAIN_W  = 8;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/answer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after 'start', wrapping mod N.
module rr_pick
    import answer_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = id_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         grant_valid,
    output logic [W-1:0] grant_id
);

    // Scan N positions starting at 'start'; the first hit wins.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(start) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid && req[idx[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = W'(idx);
            end
        end
    end

endmodule

// File: rtl/answer_arbiter.sv
// Round sequencer: host start, buzz-in arbitration, fouls, answer window, judging, scores.
module answer_arbiter
    import answer_pkg::*;
#(
    parameter  int unsigned N             = 4,
    parameter  int unsigned ARMED_CYCLES  = 20,
    parameter  int unsigned ANSWER_CYCLES = 10,
    localparam int unsigned W             = id_width(N)
) (
    input  logic                clkout,
    input  logic                rst_n,
    input  logic                host_start,
    input  logic                host_correct,
    input  logic                host_wrong,
    input  logic                host_clear,
    input  logic [N-1:0]        buzz,
    output logic [2:0]          state,
    output logic                winner_valid,
    output logic [W-1:0]        winner_id,
    output logic [N-1:0]        foul,
    output logic [N-1:0]        lockout,
    output logic [REMAIN_W-1:0] remaining,
    output logic                countdown_run,
    output logic                beep_req,
    output logic [4*N-1:0]      scores
);

    localparam logic [REMAIN_W-1:0] ARMED_R  = REMAIN_W'(ARMED_CYCLES);
    localparam logic [REMAIN_W-1:0] ANSWER_R = REMAIN_W'(ANSWER_CYCLES);
    localparam logic [REMAIN_W-1:0] ONE_R    = REMAIN_W'(1);

    state_t                state_q, state_d;
    logic                  winner_valid_d;
    logic [W-1:0]          winner_id_d;
    logic [W-1:0]          last_winner_q, last_winner_d;
    logic [N-1:0]          foul_d, lockout_d;
    logic [N-1:0]          buzz_q, press, win_mask;
    logic [REMAIN_W-1:0]   remaining_d;
    logic                  beep_d, run_d;
    logic [4*N-1:0]        scores_d;
    logic [W-1:0]          rr_start;
    logic                  grant_valid;
    logic [W-1:0]          grant_id;
    logic                  cmd_correct, cmd_wrong, cmd_start;

    assign press       = buzz & ~buzz_q;
    assign cmd_correct = host_correct;
    assign cmd_wrong   = host_wrong & ~host_correct;
    assign cmd_start   = host_start & ~host_correct & ~host_wrong;
    assign rr_start    = (last_winner_q == W'(N - 1)) ? '0 : last_winner_q + 1'b1;
    assign state       = state_q;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req         (press & ~lockout),
        .start       (rr_start),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // One-hot mask of the channel currently holding the floor.
    always_comb begin
        win_mask            = '0;
        win_mask[winner_id] = 1'b1;
    end

    // Next-state and next-output logic for the round sequencer.
    always_comb begin
        state_d        = state_q;
        winner_valid_d = winner_valid;
        winner_id_d    = winner_id;
        last_winner_d  = last_winner_q;
        foul_d         = foul;
        lockout_d      = lockout;
        remaining_d    = remaining;
        beep_d         = 1'b0;
        scores_d       = scores;

        if (host_clear) begin
            state_d        = IDLE;
            foul_d         = '0;
            lockout_d      = '0;
            winner_valid_d = 1'b0;
            remaining_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|press) begin
                        foul_d    = foul | press;
                        lockout_d = lockout | press;
                        beep_d    = 1'b1;
                    end
                    if (cmd_start && |(~(lockout | press))) begin
                        state_d     = ARMED;
                        remaining_d = ARMED_R;
                    end
                end
                ARMED: begin
                    if (grant_valid) begin
                        winner_id_d    = grant_id;
                        winner_valid_d = 1'b1;
                        last_winner_d  = grant_id;
                        state_d        = ANSWERING;
                        remaining_d    = ANSWER_R;
                        beep_d         = 1'b1;
                    end else if (remaining <= ONE_R) begin
                        state_d     = IDLE;
                        remaining_d = '0;
                        beep_d      = 1'b1;
                    end else begin
                        remaining_d = remaining - 1'b1;
                    end
                end
                ANSWERING: begin
                    if (cmd_correct) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (winner_id == W'(i) && scores[4*i +: 4] < 4'(SCORE_MAX)) begin
                                scores_d[4*i +: 4] = scores[4*i +: 4] + 4'd1;
                            end
                        end
                        state_d     = DONE;
                        remaining_d = '0;
                    end else if (cmd_wrong || remaining <= ONE_R) begin
                        lockout_d      = lockout | win_mask;
                        winner_valid_d = 1'b0;
                        if (|(~(lockout | win_mask))) begin
                            state_d     = ARMED;
                            remaining_d = ARMED_R;
                        end else begin
                            state_d     = DONE;
                            remaining_d = '0;
                        end
                    end else begin
                        remaining_d = remaining - 1'b1;
                    end
                end
                DONE: begin
                    remaining_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        run_d = (state_d == ARMED) || (state_d == ANSWERING);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            winner_valid  <= 1'b0;
            winner_id     <= '0;
            last_winner_q <= W'(N - 1);
            foul          <= '0;
            lockout       <= '0;
            remaining     <= '0;
            countdown_run <= 1'b0;
            beep_req      <= 1'b0;
            scores        <= '0;
            buzz_q        <= '0;
        end else begin
            state_q       <= state_d;
            winner_valid  <= winner_valid_d;
            winner_id     <= winner_id_d;
            last_winner_q <= last_winner_d;
            foul          <= foul_d;
            lockout       <= lockout_d;
            remaining     <= remaining_d;
            countdown_run <= run_d;
            beep_req      <= beep_d;
            scores        <= scores_d;
            buzz_q        <= buzz;
        end
    end

endmodule

// File: tb/tb_answer_arbiter.sv
// Self-checking bench for answer_arbiter: directed round scenarios plus randomized traffic
// compared every cycle against a behavioural model of the round rules.
module tb_answer_arbiter;

    localparam int N  = 4;
    localparam int AC = 20;
    localparam int WC = 10;

    logic           clkout = 1'b0;
    logic           rst_n = 1'b0;
    logic           host_start = 1'b0, host_correct = 1'b0, host_wrong = 1'b0, host_clear = 1'b0;
    logic [N-1:0]   buzz = '0;
    logic [2:0]     state;
    logic           winner_valid;
    logic [1:0]     winner_id;
    logic [N-1:0]   foul, lockout;
    logic [7:0]     remaining;
    logic           countdown_run, beep_req;
    logic [4*N-1:0] scores;

    answer_arbiter #(
        .N             (N),
        .ARMED_CYCLES  (AC),
        .ANSWER_CYCLES (WC)
    ) dut (
        .clkout        (clkout),
        .rst_n         (rst_n),
        .host_start    (host_start),
        .host_correct  (host_correct),
        .host_wrong    (host_wrong),
        .host_clear    (host_clear),
        .buzz          (buzz),
        .state         (state),
        .winner_valid  (winner_valid),
        .winner_id     (winner_id),
        .foul          (foul),
        .lockout       (lockout),
        .remaining     (remaining),
        .countdown_run (countdown_run),
        .beep_req      (beep_req),
        .scores        (scores)
    );

    always #5 clkout = ~clkout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 buzz-in open, 2 answering, 3 judged.
    int           m_state, m_wid, m_rem, m_last;
    bit           m_wv, m_beep;
    bit [N-1:0]   m_foul, m_lock, m_bq;
    int           m_score[N];

    task automatic model_reset();
        m_state = 0; m_wid = 0; m_rem = 0; m_last = N - 1;
        m_wv = 0; m_beep = 0; m_foul = '0; m_lock = '0; m_bq = '0;
        for (int i = 0; i < N; i++) m_score[i] = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit w, input bit cl, input bit [N-1:0] b);
        bit [N-1:0] pr, free, cand;
        int         pick;
        pr   = b & ~m_bq;
        m_bq = b;
        m_beep = 0;
        if (cl) begin
            m_state = 0; m_foul = '0; m_lock = '0; m_wv = 0; m_rem = 0;
        end else if (m_state == 0) begin
            if (pr != 0) begin
                m_foul |= pr; m_lock |= pr; m_beep = 1;
            end
            free = ~m_lock;
            if (s && !c && !w && free != 0) begin
                m_state = 1; m_rem = AC;
            end
        end else if (m_state == 1) begin
            cand = pr & ~m_lock;
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && cand[(m_last + k) % N]) pick = (m_last + k) % N;
            end
            if (pick >= 0) begin
                m_wid = pick; m_wv = 1; m_last = pick; m_state = 2; m_rem = WC; m_beep = 1;
            end else if (m_rem == 1) begin
                m_state = 0; m_rem = 0; m_beep = 1;
            end else begin
                m_rem--;
            end
        end else if (m_state == 2) begin
            if (c) begin
                m_score[m_wid] = (m_score[m_wid] >= 9) ? 9 : m_score[m_wid] + 1;
                m_state = 3; m_rem = 0;
            end else if (w || m_rem == 1) begin
                m_lock[m_wid] = 1'b1; m_wv = 0;
                free = ~m_lock;
                if (free != 0) begin
                    m_state = 1; m_rem = AC;
                end else begin
                    m_state = 3; m_rem = 0;
                end
            end else begin
                m_rem--;
            end
        end else begin
            m_rem = 0;
        end
    endtask

    task automatic compare_all();
        logic [4*N-1:0] exp_scores;
        for (int i = 0; i < N; i++) exp_scores[4*i +: 4] = 4'(m_score[i]);
        check("state", 64'(state), 64'(m_state));
        check("winner_valid", 64'(winner_valid), 64'(m_wv));
        check("winner_id", 64'(winner_id), 64'(m_wid));
        check("foul", 64'(foul), 64'(m_foul));
        check("lockout", 64'(lockout), 64'(m_lock));
        check("remaining", 64'(remaining), 64'(m_rem));
        check("countdown_run", 64'(countdown_run), 64'(m_state == 1 || m_state == 2));
        check("beep_req", 64'(beep_req), 64'(m_beep));
        check("scores", 64'(scores), 64'(exp_scores));
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic cyc(input bit s, input bit c, input bit w, input bit cl, input logic [N-1:0] b);
        host_start = s; host_correct = c; host_wrong = w; host_clear = cl; buzz = b;
        @(posedge clkout);
        model_step(s, c, w, cl, b);
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            beeps;
        logic [N-1:0]  rb;
        bit            rs, rc, rw, rcl;

        // Power-on reset values
        model_reset();
        #2;
        compare_all();
        check("reset_state", 64'(state), 64'd0);
        rst_n = 1'b1;

        // Simultaneous presses, round-robin from channel 0 then from channel 2
        cyc(1, 0, 0, 0, '0);
        check("armed_entry_rem", 64'(remaining), 64'(AC));
        cyc(0, 0, 0, 0, 4'b0110);
        check("rr_first_id", 64'(winner_id), 64'd1);
        check("rr_first_valid", 64'(winner_valid), 64'd1);
        cyc(0, 0, 0, 1, '0);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 4'b0110);
        check("rr_second_id", 64'(winner_id), 64'd2);
        cyc(0, 0, 0, 1, '0);

        // Early press in IDLE, then locked-out press ignored in ARMED
        cyc(0, 0, 0, 0, 4'b1000);
        check("early_foul", 64'(foul), 64'b1000);
        check("early_beep", 64'(beep_req), 64'd1);
        cyc(1, 0, 0, 0, 4'b1000);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 4'b1000);
        check("locked_press_ignored", 64'(winner_valid), 64'd0);
        cyc(0, 0, 0, 0, 4'b0001);
        check("grant_ch0", 64'(winner_id), 64'd0);
        check("grant_ch0_state", 64'(state), 64'd2);

        // Wrong answer re-arms, then buzz-in window times out
        cyc(0, 0, 1, 0, '0);
        check("wrong_lockout", 64'(lockout), 64'b1001);
        check("wrong_rearm_rem", 64'(remaining), 64'(AC));
        beeps = 0;
        for (int i = 0; i < AC; i++) begin
            cyc(0, 0, 0, 0, '0);
            beeps += int'(beep_req);
        end
        check("armed_timeout_state", 64'(state), 64'd0);
        check("armed_timeout_rem", 64'(remaining), 64'd0);
        check("armed_timeout_beeps", 64'(beeps), 64'd1);

        // Answer timeout, then exhaust every channel into DONE
        cyc(0, 0, 0, 1, '0);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 4'b0100);
        check("grant_ch2", 64'(winner_id), 64'd2);
        idle_cycles(WC);
        check("answer_timeout_lockout", 64'(lockout), 64'b0100);
        check("answer_timeout_state", 64'(state), 64'd1);
        cyc(0, 0, 0, 0, 4'b0001);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, 4'b0010);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, 4'b1000);
        check("grant_ch3", 64'(winner_id), 64'd3);
        idle_cycles(WC);
        check("all_locked", 64'(lockout), 64'b1111);
        check("all_locked_done", 64'(state), 64'd3);

        // Ten correct answers by channel 1 saturate its score at 9
        for (int r = 0; r < 10; r++) begin
            cyc(0, 0, 0, 1, '0);
            cyc(1, 0, 0, 0, '0);
            cyc(0, 0, 0, 0, 4'b0010);
            cyc(0, 1, 0, 0, '0);
        end
        check("score_saturate", 64'(scores[7:4]), 64'd9);

        // A press on the last buzz-in edge beats the timeout
        cyc(0, 0, 0, 1, '0);
        cyc(1, 0, 0, 0, '0);
        idle_cycles(AC - 1);
        check("tie_rem_one", 64'(remaining), 64'd1);
        cyc(0, 0, 0, 0, 4'b0001);
        check("tie_state", 64'(state), 64'd2);
        check("tie_valid", 64'(winner_valid), 64'd1);
        check("tie_beep", 64'(beep_req), 64'd1);

        // Randomized traffic against the model
        rb = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
            end
            rs  = ($urandom_range(0, 5) == 0);
            rc  = ($urandom_range(0, 9) == 0);
            rw  = ($urandom_range(0, 9) == 0);
            rcl = ($urandom_range(0, 39) == 0);
            cyc(rs, rc, rw, rcl, rb);
        end

        // Asynchronous reset in the middle of an answer window
        cyc(0, 0, 0, 1, '0);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 4'b0100);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 4'b0100);
        check("pre_reset_rem", 64'(remaining), 64'd5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_state", 64'(state), 64'd0);
        check("rst_valid", 64'(winner_valid), 64'd0);
        check("rst_rem", 64'(remaining), 64'd0);
        check("rst_scores", 64'(scores), 64'd0);
        check("rst_run", 64'(countdown_run), 64'd0);
        compare_all();
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 4'b0100);
        check("held_through_reset_foul", 64'(foul), 64'b0100);
        check("held_through_reset_beep", 64'(beep_req), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
